// File: rtl/mips_vector_checker_if.sv
// Vector-ROM and DUT-side signals of the vector checker.
// The master side is the checker; the slave side is the ROM plus DUT wrapper.
interface mips_vector_checker_if #(
   parameter int unsigned IN_W   = 33,
   parameter int unsigned OUT_W  = 128,
   parameter int unsigned ADDR_W = 7
);
   logic [ADDR_W-1:0]       vec_addr;
   logic [IN_W+2*OUT_W-1:0] vec_data;
   logic                    vec_valid;
   logic [IN_W-1:0]         dut_in;
   logic [OUT_W-1:0]        dut_out;

   modport master (
      output vec_addr,
      output dut_in,
      input  vec_data,
      input  vec_valid,
      input  dut_out
   );

   modport slave (
      input  vec_addr,
      input  dut_in,
      output vec_data,
      output vec_valid,
      output dut_out
   );
endinterface

// File: rtl/mips_vector_checker.sv
// Self-checking test-vector engine: fetches {stim, exp, mask} words from a synchronous ROM,
// drives the stimulus, waits SETTLE cycles, then compares the DUT outputs under the mask.
module mips_vector_checker #(
   parameter int unsigned IN_W        = 33,
   parameter int unsigned OUT_W       = 128,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned ADDR_W      = $clog2(DEPTH),
   parameter int unsigned ERR_W       = 16,
   parameter int unsigned SETTLE      = 1,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   mips_vector_checker_if.master link,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  err_pulse,
   output logic [ERR_W-1:0]      err_count,
   output logic [ADDR_W:0]       vec_count,
   output logic [ADDR_W-1:0]     first_err_idx
);

   localparam int unsigned VEC_W = IN_W + 2 * OUT_W;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StApply,
      StWait,
      StCheck,
      StDone
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [3:0]        settle_q;
   logic [OUT_W-1:0]  exp_q;
   logic [OUT_W-1:0]  mask_q;
   logic [IN_W-1:0]   dut_in_q;

   logic [IN_W-1:0]   rom_stim;
   logic [OUT_W-1:0]  rom_exp;
   logic [OUT_W-1:0]  rom_mask;
   logic              mismatch;
   logic              last_idx;
   logic [ERR_W-1:0]  err_next;

   assign link.vec_addr = idx_q;
   assign link.dut_in   = dut_in_q;

   always_comb begin
      rom_stim = link.vec_data[VEC_W-1 -: IN_W];
      rom_exp  = link.vec_data[2*OUT_W-1 -: OUT_W];
      rom_mask = link.vec_data[OUT_W-1:0];
      mismatch = |((link.dut_out ^ exp_q) & mask_q);
      last_idx = (idx_q == ADDR_W'(DEPTH - 1));
      err_next = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         settle_q      <= '0;
         exp_q         <= '0;
         mask_q        <= '0;
         dut_in_q      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_pulse     <= 1'b0;
         err_count     <= '0;
         vec_count     <= '0;
         first_err_idx <= '0;
      end else begin
         err_pulse <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  err_count     <= '0;
                  vec_count     <= '0;
                  first_err_idx <= '0;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  idx_q         <= '0;
                  busy          <= 1'b1;
                  state_q       <= StFetch;
               end
            end
            StFetch: begin
               state_q <= StApply;
            end
            StApply: begin
               if (!link.vec_valid) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (err_count == '0);
                  state_q <= StDone;
               end else begin
                  dut_in_q <= rom_stim;
                  exp_q    <= rom_exp;
                  mask_q   <= rom_mask;
                  if (SETTLE <= 1) begin
                     state_q <= StCheck;
                  end else begin
                     settle_q <= 4'(SETTLE - 1);
                     state_q  <= StWait;
                  end
               end
            end
            StWait: begin
               settle_q <= settle_q - 4'(1);
               if (settle_q <= 4'(1)) begin
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               vec_count <= vec_count + (ADDR_W + 1)'(1);
               if (mismatch) begin
                  err_pulse <= 1'b1;
                  err_count <= err_next;
                  // Count is still zero only before the first mismatch of the run.
                  if (err_count == '0) begin
                     first_err_idx <= idx_q;
                  end
               end
               if ((mismatch && STOP_ON_ERR) || last_idx) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= !mismatch && (err_count == '0);
                  state_q <= StDone;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= StFetch;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_vector_checker.sv
// Bench for mips_vector_checker: three parameterisations against a ROM/DUT model,
// results compared with a vector-list reference model.
module tb_mips_vector_checker;

   localparam int unsigned IN_W  = 33;
   localparam int unsigned OUT_W = 64;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] start = '0;

   always #5 clk = ~clk;

   logic [IN_W-1:0]  r_stim [3][DEPTH];
   logic [OUT_W-1:0] r_exp  [3][DEPTH];
   logic [OUT_W-1:0] r_mask [3][DEPTH];
   logic             r_val  [3][DEPTH];

   logic            busy_o  [3];
   logic            done_o  [3];
   logic            pass_o  [3];
   logic            pulse_o [3];
   logic [AW:0]     vcnt_o  [3];
   logic [AW-1:0]   fidx_o  [3];
   logic [15:0]     errc_o  [3];
   logic [IN_W-1:0] din_o   [3];
   logic [AW-1:0]   vaddr_o [3];

   int pulse_cnt [3];
   int n_vec  = 0;
   int n_fail = 0;

   // Behaviour of the device under test as seen by the checker.
   function automatic logic [OUT_W-1:0] dut_fn(input logic [IN_W-1:0] s);
      return {s[31:0] ^ 32'h5a5a_a5a5, s[31:0] + {31'b0, s[32]}};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_inst
      localparam int unsigned St   = (g == 1) ? 4 : (g == 2) ? 2 : 1;
      localparam bit          Stop = (g == 1);
      localparam int unsigned Ew   = (g == 2) ? 2 : 16;

      logic [Ew-1:0] ec;

      mips_vector_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(AW)) link ();

      always_ff @(posedge clk) begin
         link.vec_data  <= {r_stim[g][link.vec_addr], r_exp[g][link.vec_addr],
                            r_mask[g][link.vec_addr]};
         link.vec_valid <= r_val[g][link.vec_addr];
      end

      assign link.dut_out = dut_fn(link.dut_in);
      assign din_o[g]     = link.dut_in;
      assign vaddr_o[g]   = link.vec_addr;
      assign errc_o[g]    = 16'(ec);

      mips_vector_checker #(
         .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(AW), .ERR_W(Ew),
         .SETTLE(St), .STOP_ON_ERR(Stop)
      ) u_dut (
         .clk(clk),
         .reset(rst_n),
         .start(start[g]),
         .link(link),
         .busy(busy_o[g]),
         .done(done_o[g]),
         .pass(pass_o[g]),
         .err_pulse(pulse_o[g]),
         .err_count(ec),
         .vec_count(vcnt_o[g]),
         .first_err_idx(fidx_o[g])
      );
   end

   initial for (int k = 0; k < 3; k++) pulse_cnt[k] = 0;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (pulse_o[k] === 1'b1) pulse_cnt[k] <= pulse_cnt[k] + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int g, input string tag);
      check({tag, ".busy"},  64'(busy_o[g]),  64'(0));
      check({tag, ".done"},  64'(done_o[g]),  64'(0));
      check({tag, ".pass"},  64'(pass_o[g]),  64'(0));
      check({tag, ".pulse"}, 64'(pulse_o[g]), 64'(0));
      check({tag, ".vcnt"},  64'(vcnt_o[g]),  64'(0));
      check({tag, ".errc"},  64'(errc_o[g]),  64'(0));
      check({tag, ".fidx"},  64'(fidx_o[g]),  64'(0));
      check({tag, ".din"},   64'(din_o[g]),   64'(0));
      check({tag, ".vaddr"}, 64'(vaddr_o[g]), 64'(0));
   endtask

   // mode 0: full mask, bad vectors flip bit 5; mode 1: as 0 but bit 5 unmasked;
   // mode 2: random mask, bad vectors get random flips; mode 3: zero mask, random exp.
   task automatic fill(input int g, input int nvalid, input logic [7:0] bad, input int mode);
      for (int i = 0; i < DEPTH; i++) begin
         logic [IN_W-1:0]  s;
         logic [OUT_W-1:0] e;
         logic [OUT_W-1:0] m;
         s = {1'($urandom), $urandom};
         e = dut_fn(s);
         m = '1;
         case (mode)
            1: m[5] = 1'b0;
            2: m = {$urandom, $urandom};
            3: begin
               m = '0;
               e = {$urandom, $urandom};
            end
            default: ;
         endcase
         if (bad[i]) e = (mode == 2) ? (e ^ {$urandom, $urandom}) : (e ^ 64'h20);
         r_stim[g][i] = s;
         r_exp[g][i]  = e;
         r_mask[g][i] = m;
         r_val[g][i]  = (i < nvalid);
      end
   endtask

   // Walks the vector list and predicts the run's results and its length in cycles.
   task automatic model(input int g, output int n, output int errs, output int fidx,
                        output int pulses, output int cycles);
      int  settle;
      int  emax;
      bit  stop;
      bit  hit_end;
      settle  = (g == 1) ? 4 : (g == 2) ? 2 : 1;
      emax    = (g == 2) ? 3 : 65535;
      stop    = (g == 1);
      hit_end = 1'b0;
      n = 0; errs = 0; fidx = 0; pulses = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!r_val[g][i]) begin
            hit_end = 1'b1;
            break;
         end
         n++;
         if (((dut_fn(r_stim[g][i]) ^ r_exp[g][i]) & r_mask[g][i]) != '0) begin
            if (pulses == 0) fidx = i;
            pulses++;
            if (errs < emax) errs++;
            if (stop) break;
         end
      end
      cycles = n * (settle + 2) + (hit_end ? 2 : 0);
   endtask

   task automatic run(input int g, input string tag, input bit poke);
      int n, errs, fidx, pulses, cycles, t, p0;
      model(g, n, errs, fidx, pulses, cycles);
      p0 = pulse_cnt[g];
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      check({tag, ".busy_run"}, 64'(busy_o[g]), 64'(1));
      check({tag, ".done_run"}, 64'(done_o[g]), 64'(0));
      t = 0;
      while (done_o[g] !== 1'b1 && t < 400) begin
         if (poke && t == 3) start[g] = 1'b1;
         @(negedge clk);
         start[g] = 1'b0;
         t++;
      end
      check({tag, ".cycles"},   64'(t),          64'(cycles));
      check({tag, ".vec_count"}, 64'(vcnt_o[g]), 64'(n));
      check({tag, ".err_count"}, 64'(errc_o[g]), 64'(errs));
      check({tag, ".first_err"}, 64'(fidx_o[g]), 64'(fidx));
      check({tag, ".pass"},     64'(pass_o[g]),  64'(errs == 0));
      check({tag, ".busy_end"}, 64'(busy_o[g]),  64'(0));
      if (n > 0) check({tag, ".dut_in"}, 64'(din_o[g]), 64'(r_stim[g][n-1]));
      @(negedge clk);
      check({tag, ".pulses"}, 64'(pulse_cnt[g] - p0), 64'(pulses));
      check({tag, ".done_hold"}, 64'(done_o[g]), 64'(1));
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stim[g][i] = '0;
            r_exp[g][i]  = '0;
            r_mask[g][i] = '0;
            r_val[g][i]  = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      for (int g = 0; g < 3; g++) check_idle(g, $sformatf("reset%0d", g));
      rst_n = 1'b1;
      @(negedge clk);

      fill(0, 4, 8'h00, 0); run(0, "a_clean", 1'b0);
      fill(0, 4, 8'h04, 0); run(0, "a_bit5", 1'b0);
      fill(0, 4, 8'h04, 1); run(0, "a_bit5_masked", 1'b0);
      fill(0, 8, 8'h5a, 2); run(0, "a_full_depth", 1'b0);
      fill(0, 0, 8'h00, 0); run(0, "a_empty", 1'b0);
      fill(0, 5, 8'hff, 3); run(0, "a_mask_zero", 1'b0);
      fill(1, 7, 8'h0a, 0); run(1, "b_stop", 1'b0);
      fill(2, 6, 8'h3f, 0); run(2, "c_saturate", 1'b0);

      // Abort vector 1 in its settle wait, then rerun from scratch.
      fill(1, 6, 8'h20, 0);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (8) @(negedge clk);
      check("mid.vec_count", 64'(vcnt_o[1]), 64'(1));
      check("mid.vec_addr",  64'(vaddr_o[1]), 64'(1));
      check("mid.busy",      64'(busy_o[1]), 64'(1));
      rst_n = 1'b0;
      #1;
      check_idle(1, "mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(1, "b_rerun", 1'b1);

      for (int r = 0; r < 8; r++) begin
         int rg;
         rg = $urandom_range(0, 2);
         fill(rg, $urandom_range(0, DEPTH), 8'($urandom), $urandom_range(0, 3));
         run(rg, $sformatf("rand%0d", r), r[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_vector_checker.md
Name: mips_vector_checker

Overview:
- Synthesizable, parametrised self-checking test-vector engine for the MIPS processor and its sub-blocks (ALU, register file, control FSM); usable on FPGA and in simulation.
- Reads packed vectors (stimulus, expected, compare-mask) from a synchronous vector ROM and drives the stimulus onto the DUT.
- After a programmable settle time, compares DUT outputs under the mask, then reports error count, first failing index and pass/fail.
- Sits between the vector ROM and the DUT inside a test wrapper.

Parameters:
- IN_W, 33, stimulus width in bits (e.g. reset + memdata).
- OUT_W, 128, DUT output width compared per vector.
- DEPTH, 128, vector ROM entries.
- ADDR_W, $clog2(DEPTH), vector address width.
- ERR_W, 16, error counter width.
- SETTLE, 1, cycles between stimulus apply and compare; legal range 1..15.
- STOP_ON_ERR, 0, 1 = terminate at first mismatch; 0 = run all vectors.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run.
- vec_addr  out  ADDR_W  ROM read address.
- vec_data  in  IN_W+2*OUT_W  ROM word, packed {stim, exp, mask}; valid one cycle after vec_addr.
- vec_valid  in  1  ROM entry-valid bit, same timing as vec_data; 0 marks end of vectors.
- dut_in  out  IN_W  registered stimulus to the DUT.
- dut_out  in  OUT_W  DUT outputs.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  done && err_count==0.
- err_pulse  out  1  one-cycle pulse on each mismatch.
- err_count  out  ERR_W  mismatches seen; saturating.
- vec_count  out  ADDR_W+1  vectors checked.
- first_err_idx  out  ADDR_W  index of first failing vector; 0 if none.

Behaviour:
- Reset, asynchronous and active-low: state IDLE; all outputs 0, dut_in=0. Reset mid-run aborts immediately with no partial results kept.
- States: IDLE, FETCH, APPLY, WAIT, CHECK, DONE.
- IDLE or DONE with start=1:
  - Clear err_count, vec_count, first_err_idx, done, pass and the internal index.
  - Set busy=1 and enter FETCH.
- start while busy is ignored.
- FETCH: drive vec_addr=index; next state APPLY. The ROM word is sampled in APPLY.
- APPLY:
  - If vec_valid=0, enter DONE; dut_in is unchanged.
  - Otherwise register dut_in=stim and latch exp/mask internally.
  - If SETTLE=1 go to CHECK; else go to WAIT with the settle counter loaded to SETTLE-1.
- WAIT: decrement the settle counter; go to CHECK when it reaches 1.
- Timing: dut_out is sampled exactly SETTLE cycles after the edge that updated dut_in.
- CHECK:
  - mismatch = |((dut_out ^ exp) & mask). A mask bit of 1 means compare; mask all-0 always passes.
  - vec_count increments by 1.
  - On mismatch: err_pulse=1 and err_count+1, saturating at 2^ERR_W-1.
  - If this is the first mismatch, first_err_idx=index.
  - Next state:
    - If mismatch and STOP_ON_ERR=1, go to DONE.
    - Else if index==DEPTH-1, go to DONE. There is no wrap-around.
    - Else index+1 and go to FETCH.
- Per-vector latency: SETTLE+2 cycles (FETCH, APPLY, WAIT×(SETTLE-1), CHECK).
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - dut_in holds its last stimulus.
  - Remain until start.
- Empty ROM (vec_valid=0 at index 0): DONE with vec_count=0 and pass=1.
- Outputs are registered except vec_addr, which is driven from the index register.

Test Plan:
- Four valid vectors, DUT modelled as a register copying stim[31:0] into dut_out[31:0], exp equal to the expected copy, mask all-1, SETTLE=1 -> done after 4×3+2 cycles; vec_count=4, err_count=0, pass=1, no err_pulse.
- Same setup with vector 2 exp corrupted at bit 5 -> single err_pulse during vector 2's CHECK; err_count=1, first_err_idx=2, vec_count=4, pass=0.
- Vector 2 mismatch only in bit 5, with mask bit 5=0 -> pass=1, err_count=0.
- STOP_ON_ERR=1 with mismatches at vectors 1 and 3 -> DONE after vector 1; vec_count=2, err_count=1, first_err_idx=1.
- ERR_W=2 with 6 failing vectors -> err_count saturates at 3; first_err_idx=0.
- Reset asserted during WAIT (SETTLE=4) of vector 1, then released and start pulsed -> all outputs return to 0 immediately on reset; the rerun starts from index 0 and gives correct results. A start pulse during busy is shown to have no effect.
